// File: rtl/tt_tern_pkg.sv
// Shared ternary-weight definitions used by the weight loader and the multiplier.
//  - 2-bit ternary code points (00=0, 01=+1, 11=-1, 10=illegal)
//  - loader FSM state encoding
//  - byte-count helper for a full InLen x OutLen weight matrix
package tt_tern_pkg;

    localparam logic [1:0] TERN_ZERO = 2'b00;
    localparam logic [1:0] TERN_POS  = 2'b01;
    localparam logic [1:0] TERN_NEG  = 2'b11;
    localparam logic [1:0] TERN_ILL  = 2'b10;

    typedef enum logic [1:0] {
        LD_IDLE = 2'b00,
        LD_LOAD = 2'b01,
        LD_PEND = 2'b10
    } ld_state_e;

    // Bytes needed to carry InLen*OutLen 2-bit codes.
    function automatic int tern_nbytes(input int in_len, input int out_len);
        return (2 * in_len * out_len) / 8;
    endfunction

    // True when a code is the reserved illegal pattern.
    function automatic logic tern_is_ill(input logic [1:0] code);
        return (code == TERN_ILL);
    endfunction

endpackage

// File: rtl/tt_tern_canon.sv
// Combinational canonicaliser for one byte of four packed ternary codes.
// Ports:
//  codes_raw   in  8  four 2-bit codes, lane 0 in bits [1:0]
//  codes_canon out 8  same codes with every illegal 10 replaced by 00
//  has_ill     out 1  at least one lane held the illegal code
module tt_tern_canon
    import tt_tern_pkg::*;
(
    input  logic [7:0] codes_raw,
    output logic [7:0] codes_canon,
    output logic       has_ill
);

    // Per-lane illegal detection and replacement by zero weight.
    always_comb begin
        codes_canon = 8'h00;
        has_ill     = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (tern_is_ill(codes_raw[2*i +: 2])) begin
                codes_canon[2*i +: 2] = TERN_ZERO;
                has_ill               = 1'b1;
            end else begin
                codes_canon[2*i +: 2] = codes_raw[2*i +: 2];
            end
        end
    end

endmodule

// File: rtl/tt_weight_loader.sv
// Writer side of the ternary weight bus. Bytes of packed 2-bit codes fill a
// shadow register; the shadow is copied to the active W vector only while the
// multiplier reports idle, so W never moves under an active multiply.
// Ports:
//  clk, rst     clock and synchronous active-high reset
//  load_start   begin or restart a full load (always wins over a same-cycle byte)
//  byte_in      four codes, bits [1:0] = lowest code index
//  byte_valid   byte_in valid
//  byte_ready   loader accepts bytes (state LOAD)
//  mult_idle    commit permitted
//  W            active weights, code k at W[2*k +: 2]
//  w_valid      at least one commit since reset
//  load_done    one-cycle pulse on the commit edge
//  busy         FSM not idle
//  ill_code     sticky: an accepted byte carried an illegal code this load
module tt_weight_loader
    import tt_tern_pkg::*;
#(
    parameter int InLen  = 16,
    parameter int OutLen = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load_start,
    input  logic [7:0]                byte_in,
    input  logic                      byte_valid,
    output logic                      byte_ready,
    input  logic                      mult_idle,
    output logic [2*InLen*OutLen-1:0] W,
    output logic                      w_valid,
    output logic                      load_done,
    output logic                      busy,
    output logic                      ill_code
);

    localparam int              NBytes  = tern_nbytes(InLen, OutLen);
    localparam int              WBits   = 2 * InLen * OutLen;
    localparam int              CntW    = $clog2(NBytes);
    localparam logic [CntW-1:0] CntLast = CntW'(NBytes - 1);

    ld_state_e        state_r;
    ld_state_e        state_nxt_s;
    logic [CntW-1:0]  cnt_r;
    logic [WBits-1:0] shadow_r;
    logic [7:0]       canon_byte_s;
    logic             canon_ill_s;
    logic             accept_s;

    tt_tern_canon u_canon (
        .codes_raw   (byte_in),
        .codes_canon (canon_byte_s),
        .has_ill     (canon_ill_s)
    );

    assign byte_ready = (state_r == LD_LOAD);
    assign busy       = (state_r != LD_IDLE);
    // A restart in the same cycle discards the offered byte.
    assign accept_s   = byte_valid & byte_ready & ~load_start;

    // Next-state logic of the IDLE/LOAD/PEND loader FSM.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            LD_IDLE: begin
                if (load_start) begin
                    state_nxt_s = LD_LOAD;
                end else begin
                    state_nxt_s = LD_IDLE;
                end
            end
            LD_LOAD: begin
                if (load_start) begin
                    state_nxt_s = LD_LOAD;
                end else if (accept_s && (cnt_r == CntLast)) begin
                    state_nxt_s = LD_PEND;
                end else begin
                    state_nxt_s = LD_LOAD;
                end
            end
            LD_PEND: begin
                if (load_start) begin
                    state_nxt_s = LD_LOAD;
                end else if (mult_idle) begin
                    state_nxt_s = LD_IDLE;
                end else begin
                    state_nxt_s = LD_PEND;
                end
            end
            default: state_nxt_s = LD_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= LD_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Byte counter, shadow fill, commit to W and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r     <= '0;
            shadow_r  <= '0;
            W         <= '0;
            w_valid   <= 1'b0;
            load_done <= 1'b0;
            ill_code  <= 1'b0;
        end else begin
            load_done <= 1'b0;
            case (state_r)
                LD_IDLE: begin
                    if (load_start) begin
                        cnt_r    <= '0;
                        ill_code <= 1'b0;
                    end
                end
                LD_LOAD: begin
                    if (load_start) begin
                        cnt_r    <= '0;
                        ill_code <= 1'b0;
                    end else if (accept_s) begin
                        shadow_r[8*cnt_r +: 8] <= canon_byte_s;
                        // Counter width is exact, so the last byte wraps it to 0.
                        cnt_r <= cnt_r + CntW'(1);
                        if (canon_ill_s) begin
                            ill_code <= 1'b1;
                        end
                    end
                end
                LD_PEND: begin
                    if (load_start) begin
                        // Pending commit abandoned; W keeps its old value.
                        cnt_r    <= '0;
                        ill_code <= 1'b0;
                    end else if (mult_idle) begin
                        W         <= shadow_r;
                        w_valid   <= 1'b1;
                        load_done <= 1'b1;
                    end
                end
                default: begin
                    cnt_r <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tt_weight_loader.sv
module tb_tt_weight_loader;

    logic         clk;
    logic         rst;
    logic         load_start;
    logic [7:0]   byte_in;
    logic         byte_valid;
    logic         byte_ready;
    logic         mult_idle;
    logic [255:0] W;
    logic         w_valid;
    logic         load_done;
    logic         busy;
    logic         ill_code;

    int checks = 0;
    int errors = 0;

    logic [255:0] exp_q[$];
    logic [255:0] mon_exp;
    logic [7:0]   tbl[4];

    localparam logic [255:0] W_55  = {32{8'h55}};
    localparam logic [255:0] W_FF  = {32{8'hFF}};
    localparam logic [255:0] W_TBL = {8{32'h4CD73401}};
    localparam logic [255:0] W_ILL = {{28{8'hFF}}, 8'h00, {3{8'hFF}}};

    tt_weight_loader #(.InLen(16), .OutLen(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_start (load_start),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .mult_idle  (mult_idle),
        .W          (W),
        .w_valid    (w_valid),
        .load_done  (load_done),
        .busy       (busy),
        .ill_code   (ill_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_w(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_b(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Monitor: every commit pulse pops the next expected W from the scoreboard.
    always @(negedge clk) begin
        if (!rst && load_done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_commit: got load_done=1 expected no commit");
            end else begin
                mon_exp = exp_q.pop_front();
                check_w("commit_W", W, mon_exp);
                check_b("commit_w_valid", w_valid, 1'b1);
            end
        end
    end

    task automatic start_load();
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gaps);
        int n;
        for (int g = 0; g < gaps; g++) begin
            byte_valid = 1'b0;
            byte_in    = 8'hAA;
            @(negedge clk);
        end
        byte_valid = 1'b1;
        byte_in    = b;
        n = 0;
        while (!byte_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_b("byte_accept", byte_ready, 1'b1);
        @(negedge clk);
        byte_valid = 1'b0;
        byte_in    = 8'hAA;
    endtask

    task automatic wait_commit();
        int n;
        n = 0;
        while (!load_done && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_b("commit_seen", load_done, 1'b1);
        @(negedge clk);
    endtask

    initial begin
        tbl[0] = 8'h01;
        tbl[1] = 8'h34;
        tbl[2] = 8'hD7;
        tbl[3] = 8'h4C;
        rst        = 1'b1;
        load_start = 1'b0;
        byte_in    = 8'h00;
        byte_valid = 1'b0;
        mult_idle  = 1'b1;
        repeat (2) @(negedge clk);
        check_w("rst_W", W, 256'd0);
        check_b("rst_w_valid", w_valid, 1'b0);
        check_b("rst_busy", busy, 1'b0);
        check_b("rst_byte_ready", byte_ready, 1'b0);
        check_b("rst_load_done", load_done, 1'b0);
        check_b("rst_ill_code", ill_code, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // Full load, back-to-back bytes, commit one edge after the last byte.
        exp_q.push_back(W_55);
        start_load();
        for (int i = 0; i < 32; i++) send_byte(8'h55, 0);
        check_b("full_pend_no_done", load_done, 1'b0);
        check_b("full_pend_not_ready", byte_ready, 1'b0);
        check_b("full_pend_busy", busy, 1'b1);
        @(negedge clk);
        check_b("full_done_pulse", load_done, 1'b1);
        check_b("full_w_valid", w_valid, 1'b1);
        @(negedge clk);
        check_b("full_done_once", load_done, 1'b0);
        check_b("full_idle", busy, 1'b0);

        // Commit held off while the multiplier is busy.
        mult_idle = 1'b0;
        start_load();
        for (int i = 0; i < 32; i++) send_byte(8'hFF, 0);
        for (int i = 0; i < 10; i++) begin
            check_w("hold_W", W, W_55);
            check_b("hold_not_ready", byte_ready, 1'b0);
            check_b("hold_no_done", load_done, 1'b0);
            @(negedge clk);
        end
        exp_q.push_back(W_FF);
        mult_idle = 1'b1;
        @(negedge clk);
        check_b("hold_release_done", load_done, 1'b1);
        check_w("hold_release_W", W, W_FF);
        @(negedge clk);

        // Illegal code in byte 3 is stored as zero and flagged.
        exp_q.push_back(W_ILL);
        start_load();
        for (int i = 0; i < 32; i++) send_byte((i == 3) ? 8'hAA : 8'hFF, 0);
        wait_commit();
        check_b("ill_flag_set", ill_code, 1'b1);
        start_load();
        check_b("ill_flag_cleared", ill_code, 1'b0);

        // Restart after 5 bytes with a same-cycle byte that must be dropped.
        for (int i = 0; i < 5; i++) send_byte(8'h55, 0);
        load_start = 1'b1;
        byte_valid = 1'b1;
        byte_in    = 8'h11;
        @(negedge clk);
        load_start = 1'b0;
        byte_valid = 1'b0;
        exp_q.push_back(W_TBL);
        for (int i = 0; i < 32; i++) begin
            if (i == 31) check_b("restart_still_loading", byte_ready, 1'b1);
            send_byte(tbl[i%4], 0);
        end
        check_b("restart_pend", byte_ready, 1'b0);
        wait_commit();

        // Restart while pending: commit dropped, stale shadow overwritten.
        mult_idle = 1'b0;
        start_load();
        for (int i = 0; i < 32; i++) send_byte(8'h34, 0);
        check_b("pabort_in_pend", byte_ready, 1'b0);
        start_load();
        check_b("pabort_loading", byte_ready, 1'b1);
        check_w("pabort_W_kept", W, W_TBL);
        check_b("pabort_no_done", load_done, 1'b0);
        exp_q.push_back(256'd0);
        mult_idle = 1'b1;
        for (int i = 0; i < 32; i++) send_byte(8'h00, 0);
        wait_commit();

        // Random gaps in byte_valid: only valid bytes count, order preserved.
        exp_q.push_back(W_TBL);
        start_load();
        for (int i = 0; i < 32; i++) send_byte(tbl[i%4], int'($urandom_range(0, 2)));
        wait_commit();

        // Reset in the middle of a load clears everything, W included.
        start_load();
        for (int i = 0; i < 20; i++) send_byte(8'hFF, 0);
        rst = 1'b1;
        @(negedge clk);
        check_w("mid_rst_W", W, 256'd0);
        check_b("mid_rst_w_valid", w_valid, 1'b0);
        check_b("mid_rst_busy", busy, 1'b0);
        check_b("mid_rst_byte_ready", byte_ready, 1'b0);
        check_b("mid_rst_ill_code", ill_code, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check_b("mid_rst_stays_idle", busy, 1'b0);

        check_b("scoreboard_drained", (exp_q.size() == 0), 1'b1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
